flapjack_wb_arbiter: RTL and testbench

FLAPJACK_WB_ARBITER -- requirements
Module: flapjack_wb_arbiter

---
 rtl/flapjack_wb_arbiter.sv | 115 +++++++++++
 tb/tb_flapjack_wb_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/flapjack_wb_arbiter.sv
// Writeback arbiter: merges ALU and load-unit writebacks onto a single regfile
// write port, round-robin on contention, and tracks which registers await writeback.

module flapjack_busy_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic i_set,
    input  logic i_clr,
    output logic o_busy
);
    logic r_busy;

    // Set has priority so a same-cycle re-claim keeps the register reserved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_busy <= 1'b0;
        else if (i_set) r_busy <= 1'b1;
        else if (i_clr) r_busy <= 1'b0;
    end

    assign o_busy = r_busy;
endmodule

module flapjack_wb_arbiter #(
    parameter int WIDTH = 16,
    parameter int COUNT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             src0_valid,
    output logic             src0_ready,
    input  logic [WIDTH-1:0] src0_index,
    input  logic [WIDTH-1:0] src0_value,
    input  logic             src1_valid,
    output logic             src1_ready,
    input  logic [WIDTH-1:0] src1_index,
    input  logic [WIDTH-1:0] src1_value,
    input  logic             claim_valid,
    input  logic [WIDTH-1:0] claim_index,
    output logic             write_strobe,
    output logic [WIDTH-1:0] write_index,
    output logic [WIDTH-1:0] write_value,
    output logic [COUNT-1:0] busy,
    output logic             error
);
    typedef struct packed {
        logic [WIDTH-1:0] idx;
        logic [WIDTH-1:0] val;
    } wb_t;

    localparam logic [WIDTH-1:0] CNT_W = WIDTH'(COUNT);

    wb_t              w_src0, w_src1, w_sel, r_wb;
    logic             w_g0, w_g1, w_xfer;
    logic             w_claim_ok, w_xfer_ok, w_claim_err, w_xfer_err;
    logic [COUNT-1:0] w_claim_oh, w_xfer_oh;
    logic             r_last;   // 0 = src0 won last transfer, 1 = src1
    logic             r_strobe;
    logic             r_error;

    assign w_src0 = '{idx: src0_index, val: src0_value};
    assign w_src1 = '{idx: src1_index, val: src1_value};

    // Grant: lone requester wins; on contention the source not granted last wins.
    assign w_g0   = rst_n & src0_valid & (~src1_valid | r_last);
    assign w_g1   = rst_n & src1_valid & (~src0_valid | ~r_last);
    assign w_xfer = w_g0 | w_g1;
    assign w_sel  = w_g0 ? w_src0 : w_src1;

    assign src0_ready = w_g0;
    assign src1_ready = w_g1;

    assign w_claim_ok = claim_index < CNT_W;
    assign w_xfer_ok  = w_sel.idx < CNT_W;

    for (genvar i = 0; i < COUNT; i++) begin : g_busy
        localparam logic [WIDTH-1:0] IDX = WIDTH'(i);
        assign w_claim_oh[i] = claim_valid & (claim_index == IDX);
        assign w_xfer_oh[i]  = w_xfer & (w_sel.idx == IDX);
        flapjack_busy_cell u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_set  (w_claim_oh[i]),
            .i_clr  (w_xfer_oh[i]),
            .o_busy (busy[i])
        );
    end

    // A claim and a writeback meeting on the same register in one cycle is a
    // legal hand-over, so neither side counts it as a violation.
    assign w_claim_err = claim_valid &
                         (~w_claim_ok | (|(busy & w_claim_oh & ~w_xfer_oh)));
    assign w_xfer_err  = w_xfer &
                         (~w_xfer_ok | ~(|(w_xfer_oh & (busy | w_claim_oh))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_strobe <= 1'b0;
            r_wb     <= '0;
            r_last   <= 1'b1;
            r_error  <= 1'b0;
        end else begin
            r_strobe <= w_xfer;
            if (w_xfer) begin
                r_wb   <= w_sel;
                r_last <= w_g1;
            end
            if (w_claim_err | w_xfer_err) r_error <= 1'b1;
        end
    end

    assign write_strobe = r_strobe;
    assign write_index  = r_wb.idx;
    assign write_value  = r_wb.val;
    assign error        = r_error;
endmodule

// File: tb/tb_flapjack_wb_arbiter.sv
// Directed bench for flapjack_wb_arbiter with hand-computed expectations.

module tb_flapjack_wb_arbiter;
    localparam int WIDTH = 16;
    localparam int COUNT = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             src0_valid = 1'b0, src1_valid = 1'b0, claim_valid = 1'b0;
    logic             src0_ready, src1_ready;
    logic [WIDTH-1:0] src0_index = '0, src0_value = '0;
    logic [WIDTH-1:0] src1_index = '0, src1_value = '0;
    logic [WIDTH-1:0] claim_index = '0;
    logic             write_strobe, error;
    logic [WIDTH-1:0] write_index, write_value;
    logic [COUNT-1:0] busy;

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    flapjack_wb_arbiter #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src0_valid   (src0_valid),
        .src0_ready   (src0_ready),
        .src0_index   (src0_index),
        .src0_value   (src0_value),
        .src1_valid   (src1_valid),
        .src1_ready   (src1_ready),
        .src1_index   (src1_index),
        .src1_value   (src1_value),
        .claim_valid  (claim_valid),
        .claim_index  (claim_index),
        .write_strobe (write_strobe),
        .write_index  (write_index),
        .write_value  (write_value),
        .busy         (busy),
        .error        (error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        src0_valid  = 1'b0;
        src1_valid  = 1'b0;
        claim_valid = 1'b0;
    endtask

    task automatic do_reset;
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic claim(input logic [WIDTH-1:0] idx);
        claim_valid = 1'b1;
        claim_index = idx;
        tick();
        claim_valid = 1'b0;
    endtask

    initial begin
        // Reset state; ready must stay low even with a valid request.
        src0_valid = 1'b1;
        tick();
        chk("rst_ready0", 32'(src0_ready), 0);
        chk("rst_strobe", 32'(write_strobe), 0);
        chk("rst_windex", 32'(write_index), 0);
        chk("rst_wvalue", 32'(write_value), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_error", 32'(error), 0);
        src0_valid = 1'b0;
        rst_n = 1'b1;

        // Single claim then single writeback.
        claim(16'd3);
        chk("t1_busy_set", 32'(busy), 32'h08);
        tick();
        src0_valid = 1'b1; src0_index = 16'd3; src0_value = 16'h1234;
        #1;
        chk("t1_ready0", 32'(src0_ready), 1);
        chk("t1_ready1", 32'(src1_ready), 0);
        tick();
        src0_valid = 1'b0;
        chk("t1_strobe", 32'(write_strobe), 1);
        chk("t1_windex", 32'(write_index), 3);
        chk("t1_wvalue", 32'(write_value), 32'h1234);
        chk("t1_busy_clr", 32'(busy), 0);
        chk("t1_error", 32'(error), 0);
        tick();
        chk("t1_strobe_off", 32'(write_strobe), 0);
        chk("t1_index_hold", 32'(write_index), 3);
        chk("t1_value_hold", 32'(write_value), 32'h1234);

        // Contention straight after reset: src0 first, then src1.
        do_reset();
        claim(16'd1);
        claim(16'd2);
        chk("t2_busy", 32'(busy), 32'h06);
        src0_valid = 1'b1; src0_index = 16'd1; src0_value = 16'hAAAA;
        src1_valid = 1'b1; src1_index = 16'd2; src1_value = 16'h5555;
        #1;
        chk("t2_g0_ready0", 32'(src0_ready), 1);
        chk("t2_g0_ready1", 32'(src1_ready), 0);
        tick();
        src0_valid = 1'b0;
        chk("t2_s1_strobe", 32'(write_strobe), 1);
        chk("t2_s1_index", 32'(write_index), 1);
        chk("t2_s1_value", 32'(write_value), 32'hAAAA);
        #1;
        chk("t2_g1_ready1", 32'(src1_ready), 1);
        tick();
        src1_valid = 1'b0;
        chk("t2_s2_strobe", 32'(write_strobe), 1);
        chk("t2_s2_index", 32'(write_index), 2);
        chk("t2_s2_value", 32'(write_value), 32'h5555);
        chk("t2_busy_end", 32'(busy), 0);
        chk("t2_error", 32'(error), 0);

        // Sustained contention alternates grants, one strobe per cycle.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            src0_valid = 1'b1; src0_index = '0; src0_value = 16'(16'h0100 + i);
            src1_valid = 1'b1; src1_index = '0; src1_value = 16'(16'h0200 + i);
            #1;
            chk($sformatf("t3_ready0_%0d", i), 32'(src0_ready), (i % 2 == 0) ? 1 : 0);
            chk($sformatf("t3_ready1_%0d", i), 32'(src1_ready), (i % 2 == 1) ? 1 : 0);
            tick();
            chk($sformatf("t3_strobe_%0d", i), 32'(write_strobe), 1);
            chk($sformatf("t3_value_%0d", i), 32'(write_value),
                (i % 2 == 0) ? 32'(16'h0100 + i) : 32'(16'h0200 + i));
        end
        idle();
        chk("t3_error_unclaimed", 32'(error), 1);

        // Same-cycle claim and writeback to a busy register, then a double claim.
        do_reset();
        claim(16'd5);
        chk("t4_busy_set", 32'(busy), 32'h20);
        claim_valid = 1'b1; claim_index = 16'd5;
        src1_valid = 1'b1; src1_index = 16'd5; src1_value = 16'h0055;
        #1;
        chk("t4_ready1", 32'(src1_ready), 1);
        tick();
        src1_valid = 1'b0;
        chk("t4_busy_keep", 32'(busy), 32'h20);
        chk("t4_error_ok", 32'(error), 0);
        chk("t4_strobe", 32'(write_strobe), 1);
        chk("t4_index", 32'(write_index), 5);
        tick();
        claim_valid = 1'b0;
        chk("t4_error_dup", 32'(error), 1);
        tick();
        chk("t4_error_sticky", 32'(error), 1);

        // Out-of-range writeback is forwarded but flagged; out-of-range claim ignored.
        do_reset();
        src0_valid = 1'b1; src0_index = 16'd9; src0_value = 16'h0999;
        #1;
        chk("t5_ready0", 32'(src0_ready), 1);
        tick();
        src0_valid = 1'b0;
        chk("t5_strobe", 32'(write_strobe), 1);
        chk("t5_index", 32'(write_index), 9);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_error", 32'(error), 1);
        do_reset();
        claim(16'd8);
        chk("t5_claim_busy", 32'(busy), 0);
        chk("t5_claim_error", 32'(error), 1);

        // Reset right after a transfer drops the pending strobe.
        do_reset();
        claim(16'd2);
        src0_valid = 1'b1; src0_index = 16'd2; src0_value = 16'h7777;
        tick();
        src0_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_strobe_rst", 32'(write_strobe), 0);
        chk("t6_index_rst", 32'(write_index), 0);
        chk("t6_value_rst", 32'(write_value), 0);
        chk("t6_busy_rst", 32'(busy), 0);
        chk("t6_error_rst", 32'(error), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_strobe_after", 32'(write_strobe), 0);
        chk("t6_error_after", 32'(error), 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
